i2s_tx_serializer: RTL and testbench
====================================

// Module: i2s_tx_serializer
// PURPOSE
// - Transmit-side I2S data serializer; sits directly downstream of ws_gen and takes its bit-tick enable from clk_div.
// - Accepts stereo sample pairs from the TX FIFO over a valid/ready handshake.
// - Shifts samples MSB-first onto sd, one bit per en tick.
// - MSB is driven one bit period after each ws transition (I2S standard alignment).
// - Flags FIFO underrun and ws framing errors.
// PARAMETERS
// - DW     32  sample word width; max bits per channel slot
// - CNT_W  6   bit-counter width; must hold DW
// PORTS
// - clk        in   1    system clock; single clock domain
// - rst_       in   1    asynchronous reset, active-low
// - en         in   1    one-cycle bit-tick pulse (sclk from clk_div); all state advances only on en
// - tx_en      in   1    transmitter enable; low forces IDLE
// - OP         in   OP_t control word; only OP.frame_size used (f16bits / f32bits)
// - ws         in   1    word select from ws_gen; 0 = left, 1 = right
// - tx_l       in   DW   left sample of pair
// - tx_r       in   DW   right sample of pair
// - tx_valid   in   1    pair valid
// - tx_ready   out  1    = !pend_full; pair is accepted on any clk edge where tx_valid && tx_ready
// - sd         out  1    serial data, registered
// - underrun   out  1    one-clk pulse: left slot started with no pending pair
// - sync_err   out  1    one-clk pulse: ws changed after an unexpected bit count
// BEHAVIOUR
// - Reset values: sd=0, underrun=0, sync_err=0, state=IDLE, ws_q=1, pend_full=0 (so tx_ready=1), shift=0, bit_cnt=0.
// - Pending buffer: one pair register (pend_l, pend_r), loaded on handshake; independent of en.
// - Active buffer: act_r holds the right sample of the current frame.
// - On every en: ws_q<=ws; chg = ws ^ ws_q. No other sequential state changes between en ticks.
// - State IDLE:
//   - sd=0; bit_cnt holds 0.
//   - On en with chg && ws==0 (left start) && tx_en: enter RUN and perform a left load the same tick.
// - State RUN, left load (en && chg && ws==0):
//   - Latch fs = OP.frame_size; fs is held for the whole frame.
//   - If pend_full: word=pend_l, act_r<=pend_r, pend_full<=0.
//   - Else: word=0, act_r<=0, pulse underrun.
// - State RUN, right load (en && chg && ws==1): word=act_r.
// - Load alignment:
//   - f16bits: aligned = {word[15:0], zeros}.
//   - f32bits: aligned = word.
//   - sd<=aligned[DW-1]; shift<=aligned<<1; bit_cnt<=1.
// - RUN, en without chg: sd<=shift[DW-1]; shift<=shift<<1 (zero fill); bit_cnt saturates at DW.
//   - Bits beyond the frame size are therefore 0.
// - Framing check: on en && chg in RUN, expected = (fs==f16bits) ? 16 : 32.
//   - If bit_cnt != expected, pulse sync_err.
//   - The check is skipped on the first load after IDLE.
// - Latency: word MSB appears on sd at the en tick after ws toggles, i.e. one bit period after the ws change.
// - tx_en low: on the next en, state<=IDLE, sd<=0.
//   - pend buffer is retained; act_r and shift are cleared.
// - Simultaneous handshake and left load in the same clk: the load sees the old pend_full.
//   - If it was 0 -> underrun, and the incoming pair is stored in pend for the next frame.
// - Mid-operation async reset: all outputs return to reset values at once; any pending pair is lost.
// STRUCTURE
// - ctrl_pkg (shared): OP_t, frame_size enum (f16bits/f32bits), tx_state_t {IDLE, RUN}, localparams SLOT16=16, SLOT32=32.
// - Sub-module tx_pair_buf: single-entry valid/ready pair register (pend_l/pend_r/pend_full, pop input).
// - The serializer instantiates tx_pair_buf and holds the FSM, shift register and bit counter.
// TESTING
// - Reset, tx_en=1, ws from ws_gen (f16bits), push L=16'hA5F0 R=16'h0F0F
//   -> sd left = 1010_0101_1111_0000 starting 1 tick after ws fall; right = 0000_1111_0000_1111.
// - f32bits, L=32'h8000_0001 -> sd=1, then 30 zeros, then 1; sync_err stays 0.
// - No pair pushed before a left start -> underrun pulses once; sd=0 for both 32-bit slots.
// - tx_valid held with 3 pairs queued
//   -> tx_ready drops after the 1st accept; rises in the clk after each left load; no sample skipped.
// - Force ws toggle after 10 bits in f16bits -> sync_err pulses exactly once; next word still serialized from MSB.
// - Drop tx_en mid right slot -> sd=0 from the next en.
//   - Re-enable -> transmission resumes at the next left start with the pending pair.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S transmit path: control word, frame size and FSM states.
package ctrl_pkg;

  typedef enum logic {
    f16bits = 1'b0,
    f32bits = 1'b1
  } frame_size_t;

  typedef struct packed {
    frame_size_t frame_size;
  } OP_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  localparam int SLOT16 = 16;
  localparam int SLOT32 = 32;

  function automatic int slot_bits(input frame_size_t fs);
    return (fs == f16bits) ? SLOT16 : SLOT32;
  endfunction

endpackage

// File: rtl/tx_pair_buf.sv
// Single-entry holding register for one stereo pair between the TX FIFO and the serializer.
module tx_pair_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic [DW-1:0] tx_l,
  input  logic [DW-1:0] tx_r,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic          pop,
  output logic [DW-1:0] pend_l,
  output logic [DW-1:0] pend_r,
  output logic          pend_full
);

  logic push;

  assign tx_ready = !pend_full;
  assign push     = tx_valid && !pend_full;

  // A push only happens while empty and a pop only matters while full, so they never collide.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pend_full <= 1'b0;
      pend_l    <= '0;
      pend_r    <= '0;
    end else if (push) begin
      pend_full <= 1'b1;
      pend_l    <= tx_l;
      pend_r    <= tx_r;
    end else if (pop) begin
      pend_full <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: loads a word on each ws edge and shifts it MSB-first onto sd, one bit per en.
module i2s_tx_serializer
  import ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          en,
  input  logic          tx_en,
  input  OP_t           OP,
  input  logic          ws,
  input  logic [DW-1:0] tx_l,
  input  logic [DW-1:0] tx_r,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          sd,
  output logic          underrun,
  output logic          sync_err
);

  tx_state_t      state_reg;
  logic           ws_q_reg;
  logic [DW-1:0]  shift_reg;
  logic [DW-1:0]  act_r_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  frame_size_t    fs_reg;

  logic [DW-1:0]  pend_l;
  logic [DW-1:0]  pend_r;
  logic           pend_full;
  logic           pop;

  logic           chg;
  logic           left_load;
  logic           right_load;
  frame_size_t    load_fs;
  logic [DW-1:0]  load_word;
  logic [DW-1:0]  aligned;
  logic           frame_bad;

  tx_pair_buf #(.DW(DW)) u_pair_buf (
    .clk      (clk),
    .rst_     (rst_),
    .tx_l     (tx_l),
    .tx_r     (tx_r),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .pop      (pop),
    .pend_l   (pend_l),
    .pend_r   (pend_r),
    .pend_full(pend_full)
  );

  assign chg        = ws ^ ws_q_reg;
  assign left_load  = tx_en && chg && !ws;
  assign right_load = tx_en && chg && ws && (state_reg == RUN);
  assign pop        = en && left_load && pend_full;

  // The left load latches a new frame size; the right half reuses the size of its own frame.
  assign load_fs   = left_load ? OP.frame_size : fs_reg;
  assign load_word = left_load ? (pend_full ? pend_l : '0) : act_r_reg;
  assign aligned   = (load_fs == f16bits) ? (load_word << (DW - SLOT16)) : load_word;

  // Loads out of IDLE have no previous slot to measure, so they are never flagged.
  assign frame_bad = (state_reg == RUN) && (bit_cnt_reg != CNT_W'(slot_bits(fs_reg)));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg   <= IDLE;
      ws_q_reg    <= 1'b1;
      sd          <= 1'b0;
      underrun    <= 1'b0;
      sync_err    <= 1'b0;
      shift_reg   <= '0;
      act_r_reg   <= '0;
      bit_cnt_reg <= '0;
      fs_reg      <= f16bits;
    end else begin
      underrun <= 1'b0;
      sync_err <= 1'b0;
      if (en) begin
        ws_q_reg <= ws;
        if (!tx_en) begin
          state_reg   <= IDLE;
          sd          <= 1'b0;
          shift_reg   <= '0;
          act_r_reg   <= '0;
          bit_cnt_reg <= '0;
        end else if (left_load || right_load) begin
          state_reg   <= RUN;
          sd          <= aligned[DW-1];
          shift_reg   <= aligned << 1;
          bit_cnt_reg <= CNT_W'(1);
          sync_err    <= frame_bad;
          if (left_load) begin
            fs_reg    <= OP.frame_size;
            act_r_reg <= pend_full ? pend_r : '0;
            underrun  <= !pend_full;
          end
        end else if (state_reg == RUN) begin
          sd        <= shift_reg[DW-1];
          shift_reg <= shift_reg << 1;
          if (bit_cnt_reg != CNT_W'(DW))
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: accepted pairs are queued and compared against captured sd slots.
module tb_i2s_tx_serializer;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        en = 1'b0;
  logic        tx_en = 1'b0;
  OP_t         op;
  logic        ws = 1'b1;
  logic [31:0] tx_l = '0;
  logic [31:0] tx_r = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        sd;
  logic        underrun;
  logic        sync_err;

  int checks = 0;
  int failures = 0;
  int ur_cnt = 0;
  int se_cnt = 0;
  logic sd_s;
  logic rdy_s;

  logic [63:0] exp_q[$];
  logic [31:0] feed_l[4];
  logic [31:0] feed_r[4];
  int   feed_n = 0;
  int   feed_idx = 0;
  logic acc_pend = 1'b0;

  i2s_tx_serializer #(.DW(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .en      (en),
    .tx_en   (tx_en),
    .OP      (op),
    .ws      (ws),
    .tx_l    (tx_l),
    .tx_r    (tx_r),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .sd      (sd),
    .underrun(underrun),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // Called once per falling edge: records the pair accepted at the previous rising edge.
  task automatic feed();
    if (acc_pend) begin
      exp_q.push_back({feed_l[feed_idx], feed_r[feed_idx]});
      feed_idx++;
      acc_pend = 1'b0;
    end
    if (feed_idx < feed_n) begin
      tx_valid = 1'b1;
      tx_l = feed_l[feed_idx];
      tx_r = feed_r[feed_idx];
    end else begin
      tx_valid = 1'b0;
    end
    acc_pend = tx_valid && tx_ready;
  endtask

  task automatic start_feed(input int n);
    feed_n = n;
    feed_idx = 0;
    acc_pend = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      feed();
    end
  endtask

  task automatic tick(input logic ws_val);
    @(negedge clk);
    feed();
    ws = ws_val;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    sd_s = sd;
    rdy_s = tx_ready;
    ur_cnt += int'(underrun);
    se_cnt += int'(sync_err);
    feed();
    @(negedge clk);
    feed();
  endtask

  task automatic run_frame(input int slot, output logic [31:0] cl, output logic [31:0] cr,
                           output logic rdy_after_left);
    cl = '0;
    cr = '0;
    rdy_after_left = 1'b0;
    for (int i = 0; i < slot; i++) begin
      tick(1'b0);
      cl = {cl[30:0], sd_s};
      if (i == 0) rdy_after_left = rdy_s;
    end
    for (int i = 0; i < slot; i++) begin
      tick(1'b1);
      cr = {cr[30:0], sd_s};
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    tx_en = 1'b0;
    op.frame_size = f16bits;
    repeat (2) @(negedge clk);
    checks++; if (sd !== 1'b0) begin failures++; $display("FAIL reset_sd got=%b want=0", sd); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err got=%b want=0", sync_err); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
    @(negedge clk);
    rst_ = 1'b1;
    tx_en = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_f16();
    logic [31:0] cl, cr;
    logic ra;
    logic [63:0] e;
    int ur0, se0;
    op.frame_size = f16bits;
    feed_l[0] = 32'h1234_A5F0; feed_r[0] = 32'h5678_0F0F;
    start_feed(1);
    tick(1'b1);
    tick(1'b1);
    checks++; if (sd_s !== 1'b0) begin failures++; $display("FAIL f16_idle_sd got=%b want=0", sd_s); end
    ur0 = ur_cnt; se0 = se_cnt;
    run_frame(16, cl, cr, ra);
    pop_exp(e);
    checks++; if (cl !== {16'h0, e[47:32]}) begin failures++; $display("FAIL f16_left got=%h want=%h", cl, {16'h0, e[47:32]}); end
    checks++; if (cr !== {16'h0, e[15:0]}) begin failures++; $display("FAIL f16_right got=%h want=%h", cr, {16'h0, e[15:0]}); end
    checks++; if (ur_cnt - ur0 !== 0 || se_cnt - se0 !== 0) begin failures++; $display("FAIL f16_flags underrun=%0d sync_err=%0d want 0/0", ur_cnt - ur0, se_cnt - se0); end
    $display("test_f16 L=%h R=%h", cl[15:0], cr[15:0]);
  endtask

  task automatic test_f32();
    logic [31:0] cl, cr;
    logic ra;
    logic [63:0] e;
    int ur0, se0;
    op.frame_size = f32bits;
    feed_l[0] = 32'h8000_0001; feed_r[0] = 32'h7FFF_FFFE;
    start_feed(1);
    idle_clks(3);
    ur0 = ur_cnt; se0 = se_cnt;
    run_frame(32, cl, cr, ra);
    pop_exp(e);
    checks++; if (cl !== e[63:32]) begin failures++; $display("FAIL f32_left got=%h want=%h", cl, e[63:32]); end
    checks++; if (cr !== e[31:0]) begin failures++; $display("FAIL f32_right got=%h want=%h", cr, e[31:0]); end
    checks++; if (se_cnt - se0 !== 0) begin failures++; $display("FAIL f32_sync_err got=%0d want=0", se_cnt - se0); end
    checks++; if (ur_cnt - ur0 !== 0) begin failures++; $display("FAIL f32_underrun got=%0d want=0", ur_cnt - ur0); end
    $display("test_f32 L=%h R=%h", cl, cr);
  endtask

  task automatic test_underrun();
    logic [31:0] cl, cr;
    logic ra;
    logic [63:0] e;
    int ur0, se0;
    op.frame_size = f32bits;
    start_feed(0);
    exp_q.push_back(64'h0);
    ur0 = ur_cnt; se0 = se_cnt;
    run_frame(32, cl, cr, ra);
    pop_exp(e);
    checks++; if (cl !== e[63:32] || cr !== e[31:0]) begin failures++; $display("FAIL underrun_data got=%h/%h want=%h/%h", cl, cr, e[63:32], e[31:0]); end
    checks++; if (ur_cnt - ur0 !== 1) begin failures++; $display("FAIL underrun_pulses got=%0d want=1", ur_cnt - ur0); end
    checks++; if (se_cnt - se0 !== 0) begin failures++; $display("FAIL underrun_sync_err got=%0d want=0", se_cnt - se0); end
    $display("test_underrun pulses=%0d", ur_cnt - ur0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] cl, cr;
    logic ra;
    logic [63:0] e;
    int ur0, se0;
    op.frame_size = f32bits;
    feed_l[0] = 32'hCAFE_0001; feed_r[0] = 32'h1111_2222;
    feed_l[1] = 32'hCAFE_0002; feed_r[1] = 32'h3333_4444;
    feed_l[2] = 32'hCAFE_0003; feed_r[2] = 32'h5555_6666;
    start_feed(3);
    idle_clks(4);
    checks++; if (tx_ready !== 1'b0 || exp_q.size() != 1) begin failures++; $display("FAIL b2b_first_accept tx_ready=%b queued=%0d want 0/1", tx_ready, exp_q.size()); end
    ur0 = ur_cnt; se0 = se_cnt;
    for (int k = 0; k < 3; k++) begin
      run_frame(32, cl, cr, ra);
      pop_exp(e);
      checks++; if (ra !== 1'b1) begin failures++; $display("FAIL b2b_ready_rise frame=%0d got=%b want=1", k, ra); end
      checks++; if (cl !== e[63:32] || cr !== e[31:0]) begin failures++; $display("FAIL b2b_pair frame=%0d got=%h/%h want=%h/%h", k, cl, cr, e[63:32], e[31:0]); end
      $display("test_back_to_back frame=%0d L=%h R=%h", k, cl, cr);
    end
    checks++; if (exp_q.size() != 0 || ur_cnt - ur0 !== 0 || se_cnt - se0 !== 0) begin failures++; $display("FAIL b2b_tail queued=%0d underrun=%0d sync_err=%0d want 0/0/0", exp_q.size(), ur_cnt - ur0, se_cnt - se0); end
  endtask

  task automatic test_sync_err();
    logic [31:0] cl, cr;
    logic ra;
    logic [63:0] e;
    int se0;
    op.frame_size = f16bits;
    feed_l[0] = 32'h0000_C3A5; feed_r[0] = 32'h0000_5AF1;
    start_feed(1);
    idle_clks(3);
    se0 = se_cnt;
    cl = '0; cr = '0;
    for (int i = 0; i < 10; i++) begin tick(1'b0); cl = {cl[30:0], sd_s}; end
    for (int i = 0; i < 16; i++) begin tick(1'b1); cr = {cr[30:0], sd_s}; end
    pop_exp(e);
    checks++; if (se_cnt - se0 !== 1) begin failures++; $display("FAIL sync_err_pulse got=%0d want=1", se_cnt - se0); end
    checks++; if (cl[9:0] !== e[47:38]) begin failures++; $display("FAIL sync_err_short_left got=%h want=%h", cl[9:0], e[47:38]); end
    checks++; if (cr !== {16'h0, e[15:0]}) begin failures++; $display("FAIL sync_err_right got=%h want=%h", cr, {16'h0, e[15:0]}); end
    feed_l[0] = 32'h0000_9999; feed_r[0] = 32'h0000_6666;
    start_feed(1);
    idle_clks(3);
    run_frame(16, cl, cr, ra);
    pop_exp(e);
    checks++; if (cl !== {16'h0, e[47:32]} || cr !== {16'h0, e[15:0]}) begin failures++; $display("FAIL sync_err_recover got=%h/%h want=%h/%h", cl, cr, e[47:32], e[15:0]); end
    checks++; if (se_cnt - se0 !== 1) begin failures++; $display("FAIL sync_err_once got=%0d want=1", se_cnt - se0); end
    $display("test_sync_err pulses=%0d", se_cnt - se0);
  endtask

  task automatic test_tx_en_drop();
    logic [31:0] cl, cr;
    logic ra;
    logic [63:0] e;
    logic any_hi;
    int ur0, se0;
    op.frame_size = f16bits;
    feed_l[0] = 32'h0000_F00D; feed_r[0] = 32'h0000_BEEF;
    start_feed(1);
    idle_clks(3);
    ur0 = ur_cnt; se0 = se_cnt;
    cl = '0; cr = '0;
    for (int i = 0; i < 16; i++) begin tick(1'b0); cl = {cl[30:0], sd_s}; end
    for (int i = 0; i < 5; i++) begin tick(1'b1); cr = {cr[30:0], sd_s}; end
    tx_en = 1'b0;
    feed_l[0] = 32'h0000_1357; feed_r[0] = 32'h0000_2468;
    start_feed(1);
    idle_clks(3);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL txen_pend_held tx_ready got=%b want=0", tx_ready); end
    any_hi = 1'b0;
    for (int i = 0; i < 11; i++) begin tick(1'b1); any_hi |= sd_s; end
    for (int i = 0; i < 16; i++) begin tick(1'b0); any_hi |= sd_s; end
    for (int i = 0; i < 16; i++) begin tick(1'b1); any_hi |= sd_s; end
    checks++; if (any_hi !== 1'b0) begin failures++; $display("FAIL txen_sd_quiet got=%b want=0", any_hi); end
    pop_exp(e);
    checks++; if (cl !== {16'h0, e[47:32]} || cr[4:0] !== e[15:11]) begin failures++; $display("FAIL txen_partial got=%h/%h want=%h/%h", cl, cr[4:0], e[47:32], e[15:11]); end
    tx_en = 1'b1;
    tick(1'b1);
    tick(1'b1);
    run_frame(16, cl, cr, ra);
    pop_exp(e);
    checks++; if (cl !== {16'h0, e[47:32]} || cr !== {16'h0, e[15:0]}) begin failures++; $display("FAIL txen_resume got=%h/%h want=%h/%h", cl, cr, e[47:32], e[15:0]); end
    checks++; if (ur_cnt - ur0 !== 0 || se_cnt - se0 !== 0) begin failures++; $display("FAIL txen_flags underrun=%0d sync_err=%0d want 0/0", ur_cnt - ur0, se_cnt - se0); end
    $display("test_tx_en_drop resumed L=%h R=%h", cl[15:0], cr[15:0]);
  endtask

  task automatic test_async_reset();
    logic [31:0] cl, cr;
    logic ra;
    logic [63:0] e;
    int ur0;
    op.frame_size = f32bits;
    feed_l[0] = 32'hFFFF_FFFF; feed_r[0] = 32'h0000_0000;
    start_feed(1);
    idle_clks(3);
    for (int i = 0; i < 3; i++) tick(1'b0);
    checks++; if (sd_s !== 1'b1) begin failures++; $display("FAIL arst_pre_sd got=%b want=1", sd_s); end
    feed_l[0] = 32'h1111_1111; feed_r[0] = 32'h2222_2222;
    start_feed(1);
    idle_clks(3);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL arst_pre_ready got=%b want=0", tx_ready); end
    @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    checks++; if (sd !== 1'b0 || tx_ready !== 1'b1 || underrun !== 1'b0 || sync_err !== 1'b0) begin failures++; $display("FAIL arst_outputs sd=%b ready=%b ur=%b se=%b want 0/1/0/0", sd, tx_ready, underrun, sync_err); end
    @(negedge clk);
    rst_ = 1'b1;
    start_feed(0);
    exp_q.delete();
    exp_q.push_back(64'h0);
    ur0 = ur_cnt;
    run_frame(32, cl, cr, ra);
    pop_exp(e);
    checks++; if (cl !== e[63:32] || cr !== e[31:0]) begin failures++; $display("FAIL arst_lost_pair got=%h/%h want=%h/%h", cl, cr, e[63:32], e[31:0]); end
    checks++; if (ur_cnt - ur0 !== 1) begin failures++; $display("FAIL arst_underrun got=%0d want=1", ur_cnt - ur0); end
    $display("test_async_reset underrun=%0d", ur_cnt - ur0);
  endtask

  initial begin
    test_reset();
    test_f16();
    test_f32();
    test_underrun();
    test_back_to_back();
    test_sync_err();
    test_tx_en_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
